// File: rtl/fifo_pkg.sv
// Shared sizing helpers and occupancy-state encoding for param_fifo and its bench.
package fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } occ_state_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one asynchronous read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 4,
  localparam int PTR_W      = ptr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [PTR_W-1:0]      i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [PTR_W-1:0]      i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO: pointers, occupancy, registered status flags and sticky error
// around a fifo_mem storage array; data_out is first-word fall-through.
module param_fifo
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 4,
  parameter  int AF_LEVEL   = DEPTH - 1,
  parameter  int AE_LEVEL   = 1,
  localparam int PTR_W      = ptr_w(DEPTH),
  localparam int CNT_W      = cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  input  logic                  pop_fifo,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_W-1:0]      count,
  output logic                  err
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "param_fifo: DEPTH must be a power of two >= 2");
  end
  if (!((AE_LEVEL >= 0) && (AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
    $fatal(1, "param_fifo: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  occ_state_t            r_state, w_state_nxt;
  logic [PTR_W-1:0]      r_wp, r_rp;
  logic [CNT_W-1:0]      r_count, w_cnt_nxt;
  logic                  r_af, r_ae, r_err;
  logic                  w_empty, w_full, w_push_ok, w_pop_ok, w_err_nxt;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_empty = (r_state == EMPTY);
  assign w_full  = (r_state == FULL);

  always_comb begin
    w_push_ok   = data_in_valid & ~w_full;
    w_pop_ok    = pop_fifo & ~w_empty;
    w_cnt_nxt   = r_count;
    w_state_nxt = r_state;
    if (w_push_ok && !w_pop_ok)      w_cnt_nxt = r_count + 1'b1;
    else if (w_pop_ok && !w_push_ok) w_cnt_nxt = r_count - 1'b1;
    // A pop on an empty FIFO is only an underflow when no push arrives with it;
    // the pop is then simply absorbed and the pushed word stays.
    w_err_nxt = r_err | (data_in_valid & w_full) | (pop_fifo & w_empty & ~data_in_valid);
    unique case (r_state)
      EMPTY:   if (w_push_ok) w_state_nxt = PARTIAL;
      PARTIAL: begin
        if (w_cnt_nxt == DEPTH_C)   w_state_nxt = FULL;
        else if (w_cnt_nxt == '0)   w_state_nxt = EMPTY;
      end
      FULL:    if (w_pop_ok) w_state_nxt = PARTIAL;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_af    <= 1'b0;
      r_ae    <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_cnt_nxt;
      r_af    <= (w_cnt_nxt >= AF_C);
      r_ae    <= (w_cnt_nxt <= AE_C);
      r_err   <= w_err_nxt;
      if (w_push_ok) r_wp <= r_wp + 1'b1;
      if (w_pop_ok)  r_rp <= r_rp + 1'b1;
    end
  end

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk    (clk),
    .i_we   (w_push_ok & ~rst),
    .i_waddr(r_wp),
    .i_wdata(data_in),
    .i_raddr(r_rp),
    .o_rdata(w_rdata)
  );

  assign data_out     = w_empty ? '0 : w_rdata;
  assign fifo_empty   = w_empty;
  assign fifo_full    = w_full;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign count        = r_count;
  assign err          = r_err;

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo (DEPTH=4, 8-bit): directed vector table, wrap sequence and
// randomized traffic against a queue-based reference model.
module tb_param_fifo;
  import fifo_pkg::*;

  localparam int DW = 8;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          data_in_valid = 1'b0;
  logic          pop_fifo = 1'b0;
  logic [DW-1:0] data_out;
  logic          fifo_empty, fifo_full, almost_full, almost_empty, err;
  logic [2:0]    count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  param_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .pop_fifo     (pop_fifo),
    .data_out     (data_out),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .err          (err)
  );

  typedef struct {
    logic       r, v, p;
    logic [7:0] d;
    int         cnt;
    logic [3:0] fl;   // {empty, full, almost_full, almost_empty}
    logic [7:0] dout;
    logic       e;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, v, p, input logic [7:0] d, input int cnt,
                     input logic [3:0] fl, input logic [7:0] dout, input logic e);
    vec_t x;
    x.r = r; x.v = v; x.p = p; x.d = d; x.cnt = cnt; x.fl = fl; x.dout = dout; x.e = e;
    vt.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, v, p, input logic [7:0] d);
    rst = r; data_in_valid = v; pop_fifo = p; data_in = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] flags_of(input int n);
    return {n == 0, n == DP, n >= DP - 1, n <= 1};
  endfunction

  initial begin
    logic [7:0] q[$];
    logic       m_err;
    int         seen[3];
    logic [7:0] w;

    // reset, fill, overflow, drain
    add(1,0,0,8'h00, 0,4'b1001,8'h00,0);
    add(0,1,0,8'h11, 1,4'b0001,8'h11,0);
    add(0,1,0,8'h22, 2,4'b0000,8'h11,0);
    add(0,1,0,8'h33, 3,4'b0010,8'h11,0);
    add(0,1,0,8'h44, 4,4'b0110,8'h11,0);
    add(0,1,0,8'h55, 4,4'b0110,8'h11,1);
    add(0,0,1,8'h00, 3,4'b0010,8'h22,1);
    add(0,0,1,8'h00, 2,4'b0000,8'h33,1);
    add(0,0,1,8'h00, 1,4'b0001,8'h44,1);
    add(0,0,1,8'h00, 0,4'b1001,8'h00,1);
    // underflow
    add(1,0,0,8'h00, 0,4'b1001,8'h00,0);
    add(0,0,1,8'h00, 0,4'b1001,8'h00,1);
    // simultaneous push/pop at empty, mid, full
    add(1,0,0,8'h00, 0,4'b1001,8'h00,0);
    add(0,1,1,8'h66, 1,4'b0001,8'h66,0);
    add(0,1,0,8'h77, 2,4'b0000,8'h66,0);
    add(0,1,1,8'h88, 2,4'b0000,8'h77,0);
    add(0,0,1,8'h00, 1,4'b0001,8'h88,0);
    add(0,1,0,8'h99, 2,4'b0000,8'h88,0);
    add(0,1,0,8'hAA, 3,4'b0010,8'h88,0);
    add(0,1,0,8'hBB, 4,4'b0110,8'h88,0);
    add(0,1,1,8'hCC, 3,4'b0010,8'h99,1);
    add(0,0,1,8'h00, 2,4'b0000,8'hAA,1);
    add(0,0,1,8'h00, 1,4'b0001,8'hBB,1);
    add(0,0,1,8'h00, 0,4'b1001,8'h00,1);
    // reset mid-operation with a push pending
    add(1,0,0,8'h00, 0,4'b1001,8'h00,0);
    add(0,1,0,8'hD1, 1,4'b0001,8'hD1,0);
    add(0,1,0,8'hD2, 2,4'b0000,8'hD1,0);
    add(0,1,0,8'hD3, 3,4'b0010,8'hD1,0);
    add(1,1,0,8'hFF, 0,4'b1001,8'h00,0);
    add(0,0,0,8'h00, 0,4'b1001,8'h00,0);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].r, vt[i].v, vt[i].p, vt[i].d);
      step();
      chk($sformatf("v%0d.count", i), 32'(count), 32'(vt[i].cnt));
      chk($sformatf("v%0d.flags", i), {28'd0, fifo_empty, fifo_full, almost_full, almost_empty}, 32'(vt[i].fl));
      chk($sformatf("v%0d.dout", i), 32'(data_out), 32'(vt[i].dout));
      chk($sformatf("v%0d.err", i), 32'(err), 32'(vt[i].e));
    end

    // wrap: 10 words, two in flight, pointers wrap twice
    drive(0,1,0,8'hA0); step();
    drive(0,1,0,8'hA1); step();
    chk("wrap.prefill", 32'(count), 32'd2);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("wrap.head%0d", i), 32'(data_out), 32'(8'hA0 + i));
      if (i < 8) drive(0,1,1,8'(8'hA2 + i));
      else       drive(0,0,1,8'h00);
      step();
      chk($sformatf("wrap.count%0d", i), 32'(count), (i < 8) ? 32'd2 : (i == 8 ? 32'd1 : 32'd0));
    end
    chk("wrap.err", 32'(err), 32'd0);

    // randomized traffic against a queue model
    drive(1,0,0,8'h00); step();
    q.delete();
    m_err = 1'b0;
    seen = '{0, 0, 0};
    for (int c = 0; c < 3000; c++) begin
      logic r, v, p;
      bit   full_pre, empty_pre;
      occ_state_t st;
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 99) < 55);
      p = ($urandom_range(0, 99) < 45);
      w = 8'($urandom_range(0, 255));
      drive(r, v, p, w);
      full_pre  = (q.size() == DP);
      empty_pre = (q.size() == 0);
      if (r) begin
        q.delete();
        m_err = 1'b0;
      end else begin
        if (p && !empty_pre) void'(q.pop_front());
        if (v && !full_pre) q.push_back(w);
        if ((v && full_pre) || (p && empty_pre && !v)) m_err = 1'b1;
      end
      step();
      chk($sformatf("rnd%0d.count", c), 32'(count), 32'(q.size()));
      chk($sformatf("rnd%0d.flags", c), {28'd0, fifo_empty, fifo_full, almost_full, almost_empty},
          32'(flags_of(q.size())));
      chk($sformatf("rnd%0d.dout", c), 32'(data_out), (q.size() == 0) ? 32'd0 : 32'(q[0]));
      chk($sformatf("rnd%0d.err", c), 32'(err), 32'(m_err));
      st = (q.size() == 0) ? EMPTY : (q.size() == DP) ? FULL : PARTIAL;
      seen[int'(st)]++;
    end
    chk("cov.empty",   32'(seen[int'(EMPTY)]   > 0), 32'd1);
    chk("cov.partial", 32'(seen[int'(PARTIAL)] > 0), 32'd1);
    chk("cov.full",    32'(seen[int'(FULL)]    > 0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
